// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding unit.
package fwd_pkg;

    localparam int FWD_XLEN = 32;
    localparam int FWD_REGW = 5;
    localparam int SEL_RF   = 0;

    typedef struct packed {
        logic                vld;
        logic [FWD_REGW-1:0] rd;
        logic                dv;
        logic [FWD_XLEN-1:0] data;
    } fwd_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port selector: youngest matching producer wins; flags a hazard if its data is pending.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int XLEN  = FWD_XLEN,
    parameter int REGW  = FWD_REGW,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic [REGW-1:0]       rs,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [DEPTH-1:0]      vld,
    input  logic [DEPTH*REGW-1:0] rd,
    input  logic [DEPTH-1:0]      dv,
    input  logic [DEPTH*XLEN-1:0] data,
    output logic [XLEN-1:0]       op,
    output logic [SELW-1:0]       sel,
    output logic                  hazard
);

    logic [DEPTH-1:0] hit_s;

    // match vector; x0 never matches
    always_comb begin
        hit_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k] && (rd[k*REGW +: REGW] == rs) && (rs != '0)) begin
                hit_s[k] = 1'b1;
            end else begin
                hit_s[k] = 1'b0;
            end
        end
    end

    // walk oldest to youngest so the youngest hit is written last
    always_comb begin
        op     = rf_data;
        sel    = SELW'(SEL_RF);
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_s[k]) begin
                op     = data[k*XLEN +: XLEN];
                sel    = SELW'(k + 1);
                hazard = ~dv[k];
            end else begin
                op     = op;
                sel    = sel;
                hazard = hazard;
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: tracks the last DEPTH writes and serves NREAD operand ports.
// Optional FWD_BYPASS_STATS_EN adds saturating forward/stall counters.
module fwd_bypass_unit
    import fwd_pkg::*;
#(
    parameter int XLEN  = FWD_XLEN,
    parameter int REGW  = FWD_REGW,
    parameter int NREAD = 2,
    parameter int DEPTH = 3,
    parameter int SELW  = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    advance_i,
    input  logic                    push_we_i,
    input  logic [REGW-1:0]         push_rd_i,
    input  logic                    push_load_i,
    input  logic [XLEN-1:0]         push_data_i,
    input  logic [XLEN-1:0]         mem_rdata_i,
    input  logic                    flush_i,
    input  logic [NREAD*REGW-1:0]   rs_i,
    input  logic [NREAD*XLEN-1:0]   rf_data_i,
    output logic [NREAD*XLEN-1:0]   op_o,
    output logic [NREAD*SELW-1:0]   sel_o,
    output logic                    stall_o
`ifdef FWD_BYPASS_STATS_EN
    ,
    output logic [31:0]             fwd_cnt_o,
    output logic [31:0]             stall_cnt_o
`endif
);

    logic [DEPTH-1:0]      vld_r;
    logic [DEPTH-1:0]      dv_r;
    logic [DEPTH*REGW-1:0] rd_r;
    logic [DEPTH*XLEN-1:0] data_r;
    logic [NREAD-1:0]      haz_s;
    logic                  push_s;
    logic                  fill_s;

    assign stall_o = |haz_s;
    // a stalled cycle still advances but inserts a bubble instead of the push
    assign push_s  = push_we_i & ~stall_o & (push_rd_i != '0);
    assign fill_s  = vld_r[0] & ~dv_r[0];

    // entry shift register with push at stage 0 and load fill on 0->1
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_r  <= '0;
            dv_r   <= '0;
            rd_r   <= '0;
            data_r <= '0;
        end else if (advance_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                vld_r[k]             <= vld_r[k-1];
                rd_r[k*REGW +: REGW] <= rd_r[(k-1)*REGW +: REGW];
                if ((k == 1) && fill_s) begin
                    dv_r[k]              <= 1'b1;
                    data_r[k*XLEN +: XLEN] <= mem_rdata_i;
                end else begin
                    dv_r[k]              <= dv_r[k-1];
                    data_r[k*XLEN +: XLEN] <= data_r[(k-1)*XLEN +: XLEN];
                end
            end
            vld_r[0]        <= push_s;
            rd_r[0 +: REGW] <= push_s ? push_rd_i : '0;
            dv_r[0]         <= push_s & ~push_load_i;
            data_r[0 +: XLEN] <= (push_s && !push_load_i) ? push_data_i : '0;
        end else begin
            vld_r  <= vld_r;
            dv_r   <= dv_r;
            rd_r   <= rd_r;
            data_r <= data_r;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        fwd_port_sel #(
            .XLEN  (XLEN),
            .REGW  (REGW),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_sel (
            .rs      (rs_i[p*REGW +: REGW]),
            .rf_data (rf_data_i[p*XLEN +: XLEN]),
            .vld     (vld_r),
            .rd      (rd_r),
            .dv      (dv_r),
            .data    (data_r),
            .op      (op_o[p*XLEN +: XLEN]),
            .sel     (sel_o[p*SELW +: SELW]),
            .hazard  (haz_s[p])
        );
    end

`ifdef FWD_BYPASS_STATS_EN
    logic fwd_any_s;

    // any port served from a stage with valid data
    always_comb begin
        fwd_any_s = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if ((sel_o[p*SELW +: SELW] != SELW'(SEL_RF)) && !haz_s[p]) begin
                fwd_any_s = 1'b1;
            end else begin
                fwd_any_s = fwd_any_s;
            end
        end
    end

    // saturating event counters, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_cnt_o   <= 32'd0;
            stall_cnt_o <= 32'd0;
        end else begin
            if (fwd_any_s) begin
                fwd_cnt_o <= sat_inc32(fwd_cnt_o);
            end
            if (stall_o) begin
                stall_cnt_o <= sat_inc32(stall_cnt_o);
            end
        end
    end
`else
    // statistics not built in this configuration
`endif

endmodule
